// File: rtl/mem_access.sv
// MEM stage: word loads/stores over a req/gnt/rvalid data bus, with a pipeline stall
// while an access is outstanding and a registered MEM/WB result.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_rst_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  rd_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        memtoreg_i,
  input  logic        regwrite_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [4:0]  rd_o,
  output logic        regwrite_o,
  output logic [31:0] wb_data_o
);

  typedef enum logic [1:0] {IDLE, ADDR, RDATA} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;

  logic access, is_write, misaligned, timeout;
  logic req, stall, wb_load, rd_done, err, mis_drop;

  assign access     = memread_i | memwrite_i;
  assign is_write   = memwrite_i;
  assign misaligned = access & (alu_rst_i[1:0] != 2'b00);
  // rvalid in the final counted cycle still wins over the abort
  assign timeout    = (state == RDATA) & ~dmem_rvalid_i & (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (access && !misaligned) begin
          if (is_write && dmem_gnt_i) next_state = IDLE;
          else if (dmem_gnt_i)        next_state = RDATA;
          else                        next_state = ADDR;
        end
      end
      ADDR: begin
        if (dmem_gnt_i) next_state = is_write ? IDLE : RDATA;
      end
      RDATA: begin
        if (dmem_rvalid_i || timeout) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    stall    = 1'b0;
    wb_load  = 1'b0;
    rd_done  = 1'b0;
    err      = 1'b0;
    mis_drop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!access) wb_load = 1'b1;
        else if (misaligned) mis_drop = 1'b1;
        else begin
          req = 1'b1;
          if (is_write && dmem_gnt_i) wb_load = 1'b1;
          else                        stall   = 1'b1;
        end
      end
      ADDR: begin
        req = 1'b1;
        if (is_write && dmem_gnt_i) wb_load = 1'b1;
        else                        stall   = 1'b1;
      end
      RDATA: begin
        if (dmem_rvalid_i) rd_done = 1'b1;
        else if (timeout)  err     = 1'b1;
        else               stall   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset must silence the bus and the stall at once, not at the next edge
  assign dmem_req_o   = req & ~rst;
  assign stall_o      = stall & ~rst;
  assign dmem_we_o    = rst ? 1'b0 : is_write;
  assign dmem_addr_o  = rst ? 32'h0 : {alu_rst_i[31:2], 2'b00};
  assign dmem_wdata_o = rst ? 32'h0 : mem_wdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == RDATA && !(dmem_rvalid_i || timeout)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Anything other than a completion writes a bubble; wb_data_o keeps its value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_o       <= '0;
      regwrite_o <= 1'b0;
      wb_data_o  <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      misalign_o <= mis_drop;
      bus_err_o  <= err;
      if (wb_load) begin
        rd_o       <= rd_i;
        regwrite_o <= regwrite_i;
        wb_data_o  <= alu_rst_i;
      end else if (rd_done) begin
        rd_o       <= rd_i;
        regwrite_o <= regwrite_i;
        wb_data_o  <= memtoreg_i ? dmem_rdata_i : alu_rst_i;
      end else if (err) begin
        rd_o       <= rd_i;
        regwrite_o <= 1'b0;
        wb_data_o  <= '0;
      end else begin
        rd_o       <= '0;
        regwrite_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random ops, each checked cycle by cycle
// against a transaction-level model of stall length, bus activity and MEM/WB result.
module tb_mem_access;
  localparam int TM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_rst_i = '0, mem_wdata_i = '0, dmem_rdata_i = '0;
  logic [4:0]  rd_i = '0;
  logic        memread_i = 0, memwrite_i = 0, memtoreg_i = 0, regwrite_i = 0;
  logic        dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic        dmem_req_o, dmem_we_o, stall_o, misalign_o, bus_err_o, regwrite_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [4:0]  rd_o;

  mem_access #(.TIMEOUT(TM), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .alu_rst_i(alu_rst_i), .mem_wdata_i(mem_wdata_i),
    .rd_i(rd_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .rd_o(rd_o), .regwrite_o(regwrite_o), .wb_data_o(wb_data_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store, 3 = load+store (treated as store)
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    int          g;
    int          r;
  } op_t;

  // scoreboard: expected {rd, regwrite, data} for each op
  logic [37:0] exp_q[$];
  logic [31:0] exp_data = '0;

  task automatic run_op(input op_t op);
    logic        mem, wr, mis, tmo;
    int          total;
    logic [37:0] exp;
    mem = (op.kind != 2'd0);
    wr  = op.kind[1];
    mis = mem && (op.addr[1:0] != 2'b00);
    tmo = mem && !wr && !mis && (op.r >= TM);
    if (!mem || mis)      total = 1;
    else if (wr)          total = 1 + op.g;
    else if (op.r < TM)   total = op.g + 2 + op.r;
    else                  total = op.g + 1 + TM;
    if (mis)                 exp = {5'd0, 1'b0, exp_data};
    else if (tmo)            exp = {op.rd, 1'b0, 32'h0};
    else if (mem && !wr)     exp = {op.rd, op.rw, op.mtr ? op.rdata : op.addr};
    else                     exp = {op.rd, op.rw, op.addr};
    exp_q.push_back(exp);

    alu_rst_i   = op.addr;
    mem_wdata_i = op.wdata;
    rd_i        = op.rd;
    regwrite_i  = op.rw;
    memtoreg_i  = op.mtr;
    memread_i   = op.kind[0];
    memwrite_i  = op.kind[1];
    for (int i = 0; i < total; i++) begin
      logic req_exp;
      req_exp       = mem && !mis && (i <= op.g);
      dmem_gnt_i    = req_exp && (i == op.g);
      // rvalid outside the data phase is noise the stage must ignore
      dmem_rvalid_i = (mem && !wr && !mis && i == op.g + 1 + op.r) ||
                      ((i <= op.g || !mem || mis) && $urandom_range(0, 3) == 0);
      dmem_rdata_i  = (mem && !wr && !mis && i == op.g + 1 + op.r) ? op.rdata : $urandom;
      #1;
      check("stall", stall_o, i < total - 1);
      check("req", dmem_req_o, req_exp);
      if (req_exp) begin
        check("we", dmem_we_o, wr);
        check("addr", dmem_addr_o, {op.addr[31:2], 2'b00});
        if (wr) check("wdata", dmem_wdata_o, op.wdata);
      end
      @(posedge clk);
      #1;
      check("misalign", misalign_o, mis && i == total - 1);
      check("bus_err", bus_err_o, tmo && i == total - 1);
      if (i < total - 1) begin
        check("bubble", {rd_o, regwrite_o, wb_data_o}, {5'd0, 1'b0, exp_data});
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check("memwb", {rd_o, regwrite_o, wb_data_o}, e);
        exp_data = e[31:0];
      end
      @(negedge clk);
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  function automatic op_t mk(input logic [1:0] kind, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [4:0] rd, input logic rw, input logic mtr,
                             input int g, input int r);
    op_t o;
    o.kind = kind; o.addr = addr; o.wdata = wdata; o.rdata = rdata;
    o.rd = rd; o.rw = rw; o.mtr = mtr; o.g = g; o.r = r;
    return o;
  endfunction

  initial begin
    op_t o;
    repeat (2) @(negedge clk);
    check("rst_req", dmem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_memwb", {rd_o, regwrite_o, wb_data_o}, 0);
    check("rst_pulses", {misalign_o, bus_err_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(mk(2'd0, 32'h0000_1234, 0, 0, 5'd5, 1, 0, 0, 0));
    run_op(mk(2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 5'd0, 0, 0, 3, 0));
    run_op(mk(2'd1, 32'h0000_0200, 0, 32'hCAFE_F00D, 5'd7, 1, 1, 0, 1));
    run_op(mk(2'd1, 32'h0000_0300, 0, 32'h1111_2222, 5'd9, 1, 1, 1, 99));
    run_op(mk(2'd1, 32'h0000_0203, 0, 0, 5'd3, 1, 1, 0, 0));
    run_op(mk(2'd1, 32'h0000_0400, 0, 32'h5555_AAAA, 5'd4, 1, 1, 0, TM - 1));
    run_op(mk(2'd3, 32'h0000_0500, 32'h0BAD_F00D, 0, 5'd6, 0, 0, 0, 0));

    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_op(mk(2'($urandom_range(0, 3)), a, $urandom, $urandom, 5'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 5)));
    end

    // reset while waiting for read data
    alu_rst_i = 32'h0000_0600; rd_i = 5'd11; regwrite_i = 1; memtoreg_i = 1;
    memread_i = 1; memwrite_i = 0; dmem_gnt_i = 1;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt_i = 0;
    #1;
    check("rdata_stall", stall_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", dmem_req_o, 0);
    check("mid_rst_stall", stall_o, 0);
    check("mid_rst_memwb", {rd_o, regwrite_o, wb_data_o}, 0);
    exp_data = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(mk(2'd1, 32'h0000_0700, 0, 32'h1234_5678, 5'd12, 1, 1, 1, 0));
    run_op(mk(2'd0, 32'h0000_00AB, 0, 0, 5'd1, 1, 0, 0, 0));

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
